instr_fetch: RTL and testbench

- Fetch stage of the 16-bit RISC core.
- Holds the PC and requests instructions from instruction memory over a req/ack handshake.
- Registers each fetched word into an IF/ID pipeline register and splits it into opcode/rd/rs1/rs2 fields. The opcode field directly feeds the decode/control stage.
- Accepts a branch redirect from execute and handles stall backpressure from decode.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/ifid_reg.sv | 49 ++++
 rtl/instr_fetch.sv | 118 +++++++++++
 tb/tb_instr_fetch.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit RISC core: instruction field layout,
// NOP encoding and the fetch-stage state type.
package cpu_pkg;

  localparam int OPCODE_W = 4;
  localparam int OP_MSB   = 15;
  localparam int RD_MSB   = 11;
  localparam int RS1_MSB  = 7;
  localparam int RS2_MSB  = 3;

  localparam logic [15:0] NOP = 16'h0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2,
    S_IDLE = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: holds the fetched word and its pc, with load,
// hold and flush. Flush clears only the valid flag.
module ifid_reg
  import cpu_pkg::*;
#(
  parameter int AW = 8,
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          flush,
  input  logic [AW-1:0] pc_in,
  input  logic [IW-1:0] instr_in,
  output logic          valid,
  output logic [AW-1:0] pc,
  output logic [3:0]    opcode,
  output logic [3:0]    rd,
  output logic [3:0]    rs1,
  output logic [3:0]    rs2
);

  logic          vld_p1;
  logic [AW-1:0] pc_p1;
  logic [IW-1:0] instr_p1;

  // IF -> ID boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      pc_p1    <= '0;
      instr_p1 <= IW'(NOP);
    end else if (flush) begin
      vld_p1   <= 1'b0;
    end else if (load) begin
      vld_p1   <= 1'b1;
      pc_p1    <= pc_in;
      instr_p1 <= instr_in;
    end
  end

  assign valid  = vld_p1;
  assign pc     = pc_p1;
  assign opcode = instr_p1[OP_MSB  -: OPCODE_W];
  assign rd     = instr_p1[RD_MSB  -: 4];
  assign rs1    = instr_p1[RS1_MSB -: 4];
  assign rs2    = instr_p1[RS2_MSB -: 4];

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, imem req/ack handshake, branch redirect and IF/ID register.
// Define IFETCH_PERF_EN to add the perf_fetched / perf_stall counters.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int            AW       = 8,
  parameter int            IW       = 16,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  input  logic          id_ready,
  output logic          if_valid,
  output logic [AW-1:0] if_pc,
  output logic [3:0]    if_opcode,
  output logic [3:0]    if_rd,
  output logic [3:0]    if_rs1,
  output logic [3:0]    if_rs2,
`ifdef IFETCH_PERF_EN
  output logic [15:0]   perf_fetched,
  output logic [15:0]   perf_stall,
`endif
  input  logic          br_taken,
  input  logic [AW-1:0] br_target
);

  fetch_state_t  state, state_nx;
  logic [AW-1:0] pc, pc_nx, addr_nx;
  logic          req_nx, load, flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      imem_req  <= req_nx;
      imem_addr <= addr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    load     = 1'b0;
    flush    = 1'b0;
    case (state)
      S_REQ: begin
        // imem_req is low only in the first cycle after reset; ignore acks then
        if (imem_req && imem_ack) begin
          load     = 1'b1;
          pc_nx    = pc + AW'(1);
          state_nx = S_HOLD;
        end
      end
      S_HOLD: begin
        if (id_ready) begin
          flush    = 1'b1;
          state_nx = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_ack) state_nx = S_REQ;
      end
      default: state_nx = S_REQ;
    endcase
    if (br_taken) begin
      load     = 1'b0;
      flush    = 1'b1;
      pc_nx    = br_target;
      state_nx = (imem_req && !imem_ack) ? S_DROP : S_REQ;
    end
  end

  // A new address is issued only when no request is left unacknowledged,
  // so S_DROP keeps presenting the abandoned address until its ack.
  assign req_nx  = (state_nx == S_REQ) || (state_nx == S_DROP);
  assign addr_nx = (req_nx && (!imem_req || imem_ack)) ? pc_nx : imem_addr;

  ifid_reg #(.AW(AW), .IW(IW)) u_ifid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .flush    (flush),
    .pc_in    (pc),
    .instr_in (imem_rdata),
    .valid    (if_valid),
    .pc       (if_pc),
    .opcode   (if_opcode),
    .rd       (if_rd),
    .rs1      (if_rs1),
    .rs2      (if_rs2)
  );

`ifdef IFETCH_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (if_valid && id_ready && !br_taken) perf_fetched <= sat_inc(perf_fetched);
      if (state == S_HOLD && !id_ready)      perf_stall   <= sat_inc(perf_stall);
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, fetch, stall, redirect, wrap, async reset.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        id_ready;
  logic        if_valid;
  logic [7:0]  if_pc;
  logic [3:0]  if_opcode, if_rd, if_rs1, if_rs2;
  logic        br_taken;
  logic [7:0]  br_target;
`ifdef IFETCH_PERF_EN
  logic [15:0] perf_fetched, perf_stall;
`endif

  int vectors = 0;
  int miscompares = 0;

  instr_fetch #(.AW(8), .IW(16), .RESET_PC(8'h00)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .id_ready   (id_ready),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_opcode  (if_opcode),
    .if_rd      (if_rd),
    .if_rs1     (if_rs1),
    .if_rs2     (if_rs2),
`ifdef IFETCH_PERF_EN
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall),
`endif
    .br_taken   (br_taken),
    .br_target  (br_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_word(input logic [15:0] w);
    imem_ack = 1'b1;
    imem_rdata = w;
    tick();
    imem_ack = 1'b0;
    imem_rdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    id_ready = 1'b0; br_taken = 1'b0; br_target = '0;
    #12;
    vectors++;
    if ({imem_req, if_valid, if_pc, if_opcode, if_rd, if_rs1, if_rs2} !== 26'h0) begin
      miscompares++;
      $display("FAIL reset_state: got req=%b valid=%b pc=%h fields=%h%h%h%h, want all zero",
               imem_req, if_valid, if_pc, if_opcode, if_rd, if_rs1, if_rs2);
    end
`ifdef IFETCH_PERF_EN
    vectors++;
    if ({perf_fetched, perf_stall} !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_perf: got %h/%h, want 0/0", perf_fetched, perf_stall);
    end
`endif
    tick();
    rst_n = 1'b1;
    vectors++;
    if (imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL req_before_first_edge: got %b, want 0", imem_req);
    end
    tick();
    vectors++;
    if ({imem_req, imem_addr, if_valid} !== {1'b1, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL first_request: got req=%b addr=%h valid=%b, want 1/00/0", imem_req, imem_addr, if_valid);
    end
    ack_word(16'h1234);
    vectors++;
    if ({if_valid, if_pc, if_opcode, if_rd, if_rs1, if_rs2, imem_req} !== {1'b1, 8'h00, 16'h1234, 1'b0}) begin
      miscompares++;
      $display("FAIL first_fetch: got valid=%b pc=%h fields=%h%h%h%h req=%b, want 1/00/1234/0",
               if_valid, if_pc, if_opcode, if_rd, if_rs1, if_rs2, imem_req);
    end
  endtask

  task automatic test_stall();
    id_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if ({if_valid, if_pc, if_opcode, if_rd, if_rs1, if_rs2, imem_req} !== {1'b1, 8'h00, 16'h1234, 1'b0}) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got valid=%b pc=%h fields=%h%h%h%h req=%b, want 1/00/1234/0",
                 i, if_valid, if_pc, if_opcode, if_rd, if_rs1, if_rs2, imem_req);
      end
    end
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    vectors++;
    if ({imem_req, imem_addr, if_valid} !== {1'b1, 8'h01, 1'b0}) begin
      miscompares++;
      $display("FAIL handoff_next_req: got req=%b addr=%h valid=%b, want 1/01/0", imem_req, imem_addr, if_valid);
    end
  endtask

  task automatic test_back_to_back();
    ack_word(16'h1335);
    vectors++;
    if ({if_valid, if_pc, if_opcode, if_rd, if_rs1, if_rs2} !== {1'b1, 8'h01, 16'h1335}) begin
      miscompares++;
      $display("FAIL second_fetch: got valid=%b pc=%h fields=%h%h%h%h, want 1/01/1335",
               if_valid, if_pc, if_opcode, if_rd, if_rs1, if_rs2);
    end
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    vectors++;
    if ({imem_req, imem_addr} !== {1'b1, 8'h02}) begin
      miscompares++;
      $display("FAIL third_req: got req=%b addr=%h, want 1/02", imem_req, imem_addr);
    end
  endtask

  task automatic test_branch_drop();
    ack_word(16'h1436);
    vectors++;
    if ({if_valid, if_pc, if_opcode, if_rd, if_rs1, if_rs2} !== {1'b1, 8'h02, 16'h1436}) begin
      miscompares++;
      $display("FAIL fetch_02: got valid=%b pc=%h fields=%h%h%h%h, want 1/02/1436",
               if_valid, if_pc, if_opcode, if_rd, if_rs1, if_rs2);
    end
    // redirect coincident with a decode handoff: flush must win
    br_taken = 1'b1; br_target = 8'h05; id_ready = 1'b1;
    tick();
    br_taken = 1'b0; id_ready = 1'b0;
    vectors++;
    if ({if_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 8'h05}) begin
      miscompares++;
      $display("FAIL br_in_hold: got valid=%b req=%b addr=%h, want 0/1/05", if_valid, imem_req, imem_addr);
    end
    tick();
    br_taken = 1'b1; br_target = 8'h40;
    tick();
    br_taken = 1'b0;
    vectors++;
    if ({if_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 8'h05}) begin
      miscompares++;
      $display("FAIL drop_holds_addr: got valid=%b req=%b addr=%h, want 0/1/05", if_valid, imem_req, imem_addr);
    end
    tick();
    vectors++;
    if ({if_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 8'h05}) begin
      miscompares++;
      $display("FAIL drop_wait: got valid=%b req=%b addr=%h, want 0/1/05", if_valid, imem_req, imem_addr);
    end
    ack_word(16'h1739);
    vectors++;
    if ({if_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 8'h40}) begin
      miscompares++;
      $display("FAIL drop_discard: got valid=%b req=%b addr=%h, want 0/1/40", if_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_branch_ack();
    ack_word(16'h5274);
    vectors++;
    if ({if_valid, if_pc, if_opcode, if_rd, if_rs1, if_rs2} !== {1'b1, 8'h40, 16'h5274}) begin
      miscompares++;
      $display("FAIL fetch_40: got valid=%b pc=%h fields=%h%h%h%h, want 1/40/5274",
               if_valid, if_pc, if_opcode, if_rd, if_rs1, if_rs2);
    end
    br_taken = 1'b1; br_target = 8'h10;
    tick();
    br_taken = 1'b0;
    vectors++;
    if ({if_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 8'h10}) begin
      miscompares++;
      $display("FAIL br_stalled_hold: got valid=%b req=%b addr=%h, want 0/1/10", if_valid, imem_req, imem_addr);
    end
    br_taken = 1'b1; br_target = 8'h20;
    ack_word(16'h2244);
    br_taken = 1'b0;
    vectors++;
    if ({if_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 8'h20}) begin
      miscompares++;
      $display("FAIL br_with_ack: got valid=%b req=%b addr=%h, want 0/1/20", if_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap();
    br_taken = 1'b1; br_target = 8'hFF;
    ack_word(16'h3254);
    br_taken = 1'b0;
    vectors++;
    if ({if_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 8'hFF}) begin
      miscompares++;
      $display("FAIL wrap_req_ff: got valid=%b req=%b addr=%h, want 0/1/ff", if_valid, imem_req, imem_addr);
    end
    ack_word(16'h1133);
    vectors++;
    if ({if_valid, if_pc, if_opcode, if_rd, if_rs1, if_rs2} !== {1'b1, 8'hFF, 16'h1133}) begin
      miscompares++;
      $display("FAIL fetch_ff: got valid=%b pc=%h fields=%h%h%h%h, want 1/ff/1133",
               if_valid, if_pc, if_opcode, if_rd, if_rs1, if_rs2);
    end
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    vectors++;
    if ({imem_req, imem_addr} !== {1'b1, 8'h00}) begin
      miscompares++;
      $display("FAIL pc_wrap: got req=%b addr=%h, want 1/00", imem_req, imem_addr);
    end
  endtask

  task automatic test_async_reset();
    ack_word(16'h1234);
    vectors++;
    if ({if_valid, if_pc, if_opcode, if_rd, if_rs1, if_rs2} !== {1'b1, 8'h00, 16'h1234}) begin
      miscompares++;
      $display("FAIL fetch_after_wrap: got valid=%b pc=%h fields=%h%h%h%h, want 1/00/1234",
               if_valid, if_pc, if_opcode, if_rd, if_rs1, if_rs2);
    end
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({imem_req, if_valid, if_pc, if_opcode, if_rd, if_rs1, if_rs2} !== 26'h0) begin
      miscompares++;
      $display("FAIL async_reset: got req=%b valid=%b pc=%h fields=%h%h%h%h, want all zero",
               imem_req, if_valid, if_pc, if_opcode, if_rd, if_rs1, if_rs2);
    end
    tick();
    rst_n = 1'b1;
    tick();
    vectors++;
    if ({imem_req, imem_addr, if_valid} !== {1'b1, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL req_after_reset: got req=%b addr=%h valid=%b, want 1/00/0", imem_req, imem_addr, if_valid);
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_back_to_back();
    test_branch_drop();
    test_branch_ack();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
